// File: rtl/gates_unit_pipe_if.sv
// Handshake and data bundle between an operand source / result sink and gates_unit_pipe.
// The master side drives operands and out_ready; the slave side is the logic unit.
interface gates_unit_pipe_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] f;
    logic             zero;
    logic             parity;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, f, zero, parity
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, f, zero, parity
    );
endinterface

// File: rtl/gates_unit_pipe.sv
// Two-stage pipelined WIDTH-bit bitwise logic unit with valid/ready on both sides,
// registered zero/parity flags and a wrapping delivered-result counter.
module gates_unit_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    gates_unit_pipe_if.slave    bus,
    output logic [CNT_W-1:0]    result_cnt
);

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [2:0]       s1_op;

    logic             out_valid_q;
    logic [WIDTH-1:0] f_q;
    logic             zero_q;
    logic             parity_q;
    logic [CNT_W-1:0] cnt_q;

    logic [WIDTH-1:0] s1_res;
    logic             s2_free;
    logic             s1_adv;
    logic             ready;
    logic             accept;
    logic             deliver;

    always_comb begin
        s1_res = s1_b;
        case (s1_op)
            3'd0:    s1_res = s1_a & s1_b;
            3'd1:    s1_res = s1_a | s1_b;
            3'd2:    s1_res = ~s1_a;
            3'd3:    s1_res = ~(s1_a & s1_b);
            3'd4:    s1_res = ~(s1_a | s1_b);
            3'd5:    s1_res = s1_a ^ s1_b;
            3'd6:    s1_res = ~(s1_a ^ s1_b);
            default: s1_res = s1_b;
        endcase
    end

    // in_ready depends only on pipeline state and out_ready, never on in_valid.
    assign s2_free = !out_valid_q || bus.out_ready;
    assign s1_adv  = s1_valid && s2_free;
    assign ready   = !s1_valid || s2_free;
    assign accept  = bus.in_valid && ready;
    assign deliver = out_valid_q && bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid    <= 1'b0;
            s1_a        <= '0;
            s1_b        <= '0;
            s1_op       <= '0;
            out_valid_q <= 1'b0;
            f_q         <= '0;
            zero_q      <= 1'b0;
            parity_q    <= 1'b0;
            cnt_q       <= '0;
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
                s1_a     <= bus.a;
                s1_b     <= bus.b;
                s1_op    <= bus.op;
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end

            if (s1_adv) begin
                out_valid_q <= 1'b1;
                f_q         <= s1_res;
                zero_q      <= (s1_res == '0);
                parity_q    <= ^s1_res;
            end else if (deliver) begin
                out_valid_q <= 1'b0;
            end

            if (deliver) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = out_valid_q;
    assign bus.f         = f_q;
    assign bus.zero      = zero_q;
    assign bus.parity    = parity_q;
    assign result_cnt    = cnt_q;

endmodule

// File: tb/tb_gates_unit_pipe.sv
// Directed bench for gates_unit_pipe: an 8-bit instance for pipeline behaviour
// and a 1-bit instance for the single-bit gate truth tables.
module tb_gates_unit_pipe;

    logic       clk;
    logic       rst;
    logic [7:0] cnt8;
    logic [7:0] cnt1;

    int checks;
    int errors;

    gates_unit_pipe_if #(.WIDTH(8)) bus8 ();
    gates_unit_pipe_if #(.WIDTH(1)) bus1 ();

    gates_unit_pipe #(.WIDTH(8), .CNT_W(8)) dut8 (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus8.slave),
        .result_cnt (cnt8)
    );

    gates_unit_pipe #(.WIDTH(1), .CNT_W(8)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus1.slave),
        .result_cnt (cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus8.in_valid = 1'b0;
        bus1.in_valid = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        checks++; if (bus8.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus8.out_valid); end
        checks++; if (bus8.f !== 8'h00) begin errors++; $display("FAIL reset_f: got %h expected 00", bus8.f); end
        checks++; if (bus8.zero !== 1'b0 || bus8.parity !== 1'b0) begin errors++; $display("FAIL reset_flags: got zero=%b parity=%b expected 0 0", bus8.zero, bus8.parity); end
        checks++; if (cnt8 !== 8'h00) begin errors++; $display("FAIL reset_cnt: got %h expected 00", cnt8); end
        checks++; if (bus8.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", bus8.in_ready); end
    endtask

    task automatic test_sweep();
        logic [7:0] exp_f [8];
        exp_f = '{8'hC0, 8'hFC, 8'h0F, 8'h3F, 8'h03, 8'h3C, 8'hC3, 8'hCC};
        do_reset();
        bus8.out_ready = 1'b1;
        bus8.a = 8'hF0;
        bus8.b = 8'hCC;
        for (int j = 0; j < 10; j++) begin
            bus8.in_valid = (j < 8);
            bus8.op = 3'(j);
            tick();
            if (j >= 1 && j <= 8) begin
                checks++; if (bus8.out_valid !== 1'b1 || bus8.f !== exp_f[j-1])
                    begin errors++; $display("FAIL sweep_op%0d: got valid=%b f=%h expected valid=1 f=%h", j-1, bus8.out_valid, bus8.f, exp_f[j-1]); end
            end else begin
                checks++; if (bus8.out_valid !== 1'b0) begin errors++; $display("FAIL sweep_idle_step%0d: got valid=%b expected 0", j, bus8.out_valid); end
            end
        end
        checks++; if (cnt8 !== 8'd8) begin errors++; $display("FAIL sweep_cnt: got %0d expected 8", cnt8); end
    endtask

    task automatic test_flags();
        do_reset();
        bus8.out_ready = 1'b1;
        bus8.in_valid = 1'b1;
        bus8.op = 3'd0; bus8.a = 8'h0F; bus8.b = 8'hF0;
        tick();
        bus8.op = 3'd5; bus8.a = 8'h01; bus8.b = 8'h00;
        tick();
        bus8.in_valid = 1'b0;
        checks++; if (bus8.out_valid !== 1'b1 || bus8.f !== 8'h00 || bus8.zero !== 1'b1 || bus8.parity !== 1'b0)
            begin errors++; $display("FAIL flags_zero: got v=%b f=%h z=%b p=%b expected v=1 f=00 z=1 p=0", bus8.out_valid, bus8.f, bus8.zero, bus8.parity); end
        tick();
        checks++; if (bus8.out_valid !== 1'b1 || bus8.f !== 8'h01 || bus8.zero !== 1'b0 || bus8.parity !== 1'b1)
            begin errors++; $display("FAIL flags_parity: got v=%b f=%h z=%b p=%b expected v=1 f=01 z=0 p=1", bus8.out_valid, bus8.f, bus8.zero, bus8.parity); end
        tick();
        checks++; if (bus8.out_valid !== 1'b0 || bus8.parity !== 1'b1)
            begin errors++; $display("FAIL flags_hold: got v=%b p=%b expected v=0 p=1", bus8.out_valid, bus8.parity); end
    endtask

    task automatic test_backpressure();
        int  idx;
        int  got;
        logic acc;
        logic hso;
        logic [7:0] fo;
        do_reset();
        bus8.out_ready = 1'b0;
        bus8.op = 3'd1;
        bus8.b = 8'h10;
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            bus8.in_valid = (idx < 4);
            bus8.a = 8'(idx);
            #1;
            acc = bus8.in_valid && bus8.in_ready;
            tick();
            if (acc) idx++;
        end
        checks++; if (idx !== 2) begin errors++; $display("FAIL bp_accepted: got %0d expected 2", idx); end
        checks++; if (bus8.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b expected 0", bus8.in_ready); end
        checks++; if (bus8.out_valid !== 1'b1 || bus8.f !== 8'h10) begin errors++; $display("FAIL bp_stall_f: got v=%b f=%h expected v=1 f=10", bus8.out_valid, bus8.f); end
        bus8.out_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 20 && got < 4; c++) begin
            bus8.in_valid = (idx < 4);
            bus8.a = 8'(idx);
            #1;
            acc = bus8.in_valid && bus8.in_ready;
            hso = bus8.out_valid && bus8.out_ready;
            fo = bus8.f;
            tick();
            if (acc) idx++;
            if (hso) begin
                checks++; if (fo !== 8'h10 + 8'(got)) begin errors++; $display("FAIL bp_order%0d: got %h expected %h", got, fo, 8'h10 + 8'(got)); end
                got++;
            end
        end
        bus8.in_valid = 1'b0;
        checks++; if (got !== 4) begin errors++; $display("FAIL bp_delivered: got %0d expected 4", got); end
        checks++; if (cnt8 !== 8'd4) begin errors++; $display("FAIL bp_cnt: got %0d expected 4", cnt8); end
        checks++; if (bus8.out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup: got valid=%b expected 0", bus8.out_valid); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus8.out_ready = 1'b0;
        bus8.in_valid = 1'b1;
        bus8.op = 3'd0; bus8.a = 8'hFF; bus8.b = 8'h0F;
        tick();
        bus8.op = 3'd1; bus8.a = 8'hF0; bus8.b = 8'h0F;
        tick();
        bus8.out_ready = 1'b1;
        bus8.op = 3'd5; bus8.a = 8'hFF; bus8.b = 8'hFF;
        #1;
        checks++; if (bus8.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready_full: got %b expected 1", bus8.in_ready); end
        tick();
        checks++; if (bus8.out_valid !== 1'b1 || bus8.f !== 8'hFF || cnt8 !== 8'd1)
            begin errors++; $display("FAIL b2b_step1: got v=%b f=%h cnt=%0d expected v=1 f=FF cnt=1", bus8.out_valid, bus8.f, cnt8); end
        bus8.op = 3'd7; bus8.a = 8'h00; bus8.b = 8'h5A;
        tick();
        bus8.in_valid = 1'b0;
        checks++; if (bus8.out_valid !== 1'b1 || bus8.f !== 8'h00 || bus8.zero !== 1'b1 || cnt8 !== 8'd2)
            begin errors++; $display("FAIL b2b_step2: got v=%b f=%h z=%b cnt=%0d expected v=1 f=00 z=1 cnt=2", bus8.out_valid, bus8.f, bus8.zero, cnt8); end
        tick();
        checks++; if (bus8.out_valid !== 1'b1 || bus8.f !== 8'h5A || cnt8 !== 8'd3)
            begin errors++; $display("FAIL b2b_step3: got v=%b f=%h cnt=%0d expected v=1 f=5A cnt=3", bus8.out_valid, bus8.f, cnt8); end
        tick();
        checks++; if (bus8.out_valid !== 1'b0 || cnt8 !== 8'd4)
            begin errors++; $display("FAIL b2b_drain: got v=%b cnt=%0d expected v=0 cnt=4", bus8.out_valid, cnt8); end
    endtask

    task automatic test_reset_midstream();
        // counter holds 4 from the previous scenario; two beats go in flight
        bus8.out_ready = 1'b0;
        bus8.in_valid = 1'b1;
        bus8.op = 3'd2; bus8.a = 8'h00; bus8.b = 8'h00;
        tick();
        tick();
        checks++; if (bus8.out_valid !== 1'b1 || bus8.in_ready !== 1'b0)
            begin errors++; $display("FAIL mid_full: got v=%b rdy=%b expected v=1 rdy=0", bus8.out_valid, bus8.in_ready); end
        rst = 1'b1;
        bus8.out_ready = 1'b1;
        tick();
        rst = 1'b0;
        bus8.in_valid = 1'b0;
        #1;
        checks++; if (bus8.out_valid !== 1'b0 || bus8.f !== 8'h00 || bus8.zero !== 1'b0)
            begin errors++; $display("FAIL mid_clear: got v=%b f=%h z=%b expected v=0 f=00 z=0", bus8.out_valid, bus8.f, bus8.zero); end
        checks++; if (cnt8 !== 8'd0) begin errors++; $display("FAIL mid_cnt: got %0d expected 0", cnt8); end
        checks++; if (bus8.in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready: got %b expected 1", bus8.in_ready); end
        tick();
        tick();
        checks++; if (bus8.out_valid !== 1'b0 || cnt8 !== 8'd0)
            begin errors++; $display("FAIL mid_no_partial: got v=%b cnt=%0d expected v=0 cnt=0", bus8.out_valid, cnt8); end
    endtask

    task automatic test_wrap();
        int   acc_n;
        int   del_n;
        logic acc;
        logic hso;
        do_reset();
        bus8.out_ready = 1'b1;
        bus8.op = 3'd5;
        acc_n = 0;
        del_n = 0;
        for (int c = 0; c < 400 && del_n < 256; c++) begin
            bus8.in_valid = (acc_n < 256);
            bus8.a = 8'(acc_n);
            bus8.b = 8'h33;
            #1;
            acc = bus8.in_valid && bus8.in_ready;
            hso = bus8.out_valid && bus8.out_ready;
            tick();
            if (acc) acc_n++;
            if (hso) begin
                del_n++;
                if (del_n == 255) begin
                    checks++; if (cnt8 !== 8'hFF) begin errors++; $display("FAIL wrap_ff: got %h expected FF", cnt8); end
                end
            end
        end
        bus8.in_valid = 1'b0;
        checks++; if (del_n !== 256) begin errors++; $display("FAIL wrap_delivered: got %0d expected 256 (timeout)", del_n); end
        checks++; if (cnt8 !== 8'h00) begin errors++; $display("FAIL wrap_zero: got %h expected 00", cnt8); end
    endtask

    task automatic test_width1();
        // truth table per op, bit index = {a,b}
        logic [3:0] tt [8];
        int         op_i;
        int         ab_i;
        logic       exp_bit;
        tt = '{4'b1000, 4'b1110, 4'b0011, 4'b0111, 4'b0001, 4'b0110, 4'b1001, 4'b1010};
        do_reset();
        bus1.out_ready = 1'b1;
        for (int j = 0; j <= 32; j++) begin
            bus1.in_valid = (j < 32);
            bus1.op = 3'(j / 4);
            bus1.a  = 1'((j % 4) / 2);
            bus1.b  = 1'(j % 2);
            tick();
            if (j >= 1) begin
                op_i = (j - 1) / 4;
                ab_i = (j - 1) % 4;
                exp_bit = tt[op_i][ab_i];
                checks++; if (bus1.out_valid !== 1'b1 || bus1.f !== exp_bit || bus1.parity !== exp_bit)
                    begin errors++; $display("FAIL w1_op%0d_ab%0d: got v=%b f=%b p=%b expected v=1 f=%b p=%b", op_i, ab_i, bus1.out_valid, bus1.f, bus1.parity, exp_bit, exp_bit); end
            end
        end
        bus1.in_valid = 1'b0;
        tick();
        checks++; if (cnt1 !== 8'd32) begin errors++; $display("FAIL w1_cnt: got %0d expected 32", cnt1); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.op = '0; bus8.out_ready = 1'b0;
        bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.op = '0; bus1.out_ready = 1'b0;
        test_reset();
        test_sweep();
        test_flags();
        test_backpressure();
        test_back_to_back();
        test_reset_midstream();
        test_wrap();
        test_width1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
